ppi_bus_master: RTL and testbench

//  Synchronous host-side bus sequencer that drives the 8255-style PPI bus (cs, a1/a0, wrb, rdb, data).

---
 rtl/ppi_bus_master_if.sv | 29 ++
 rtl/ppi_bus_master.sv | 146 ++++++++++++++
 tb/tb_ppi_bus_master.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppi_bus_master_if.sv
// Host request/response channel and PPI-side bus signals of ppi_bus_master.
// The master modport is the sequencer's view; the slave modport is the host/PPI side.
interface ppi_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cs;
  logic       a1;
  logic       a0;
  logic       wrb;
  logic       rdb;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, data_in,
    output req_ready, rsp_valid, rsp_rdata, cs, a1, a0, wrb, rdb, data_out, data_oe
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, data_in,
    input  req_ready, rsp_valid, rsp_rdata, cs, a1, a0, wrb, rdb, data_out, data_oe
  );
endinterface

// File: rtl/ppi_bus_master.sv
// Host-side sequencer turning single-beat valid/ready requests into timed 8255-style PPI
// bus cycles (setup, strobe, hold) followed by a one-cycle response pulse.
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned CNT_W      = 4
) (
  input logic             clk,
  input logic             reset,
  ppi_bus_master_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetup  = 3'd1;
  localparam logic [2:0] StStrobe = 3'd2;
  localparam logic [2:0] StHold   = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  localparam logic [CNT_W-1:0] SetupLast  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] StrobeLast = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             cs_q, cs_d;
  logic [1:0]       addr_q, addr_d;
  logic             wrb_q, wrb_d;
  logic             rdb_q, rdb_d;
  logic [7:0]       dout_q, dout_d;
  logic             oe_q, oe_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    cs_d        = cs_q;
    addr_d      = addr_q;
    wrb_d       = wrb_q;
    rdb_d       = rdb_q;
    dout_d      = dout_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StSetup;
          cnt_d   = '0;
          wr_d    = bus.req_write;
          cs_d    = 1'b0;
          addr_d  = bus.req_addr;
          dout_d  = bus.req_wdata;
          oe_d    = bus.req_write;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StStrobe;
          cnt_d   = '0;
          wrb_d   = ~wr_q;
          rdb_d   = wr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          cnt_d   = '0;
          wrb_d   = 1'b1;
          rdb_d   = 1'b1;
          // Capture on the same edge that releases rdb.
          if (!wr_q) begin
            rdata_d = bus.data_in;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d     = StResp;
          cnt_d       = '0;
          cs_d        = 1'b1;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          if (wr_q) begin
            rdata_d = 8'h00;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      cs_q        <= 1'b1;
      addr_q      <= 2'b00;
      wrb_q       <= 1'b1;
      rdb_q       <= 1'b1;
      dout_q      <= 8'h00;
      oe_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      wrb_q       <= wrb_d;
      rdb_q       <= rdb_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.cs        = cs_q;
  assign bus.a1        = addr_q[1];
  assign bus.a0        = addr_q[0];
  assign bus.wrb       = wrb_q;
  assign bus.rdb       = rdb_q;
  assign bus.data_out  = dout_q;
  assign bus.data_oe   = oe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: default-timing instance plus a stretched-timing instance
// (SETUP=3, STROBE=4, HOLD=2), checked by cycle-accurate traces of each transaction.
module tb_ppi_bus_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       req_valid1, req_valid2, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata, din;

  ppi_bus_master_if bus1 ();
  ppi_bus_master_if bus2 ();

  assign bus1.req_valid = req_valid1;
  assign bus2.req_valid = req_valid2;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus1.data_in   = din;
  assign bus2.data_in   = din;

  ppi_bus_master u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.master)
  );

  ppi_bus_master #(
    .SETUP_CYC (3),
    .STROBE_CYC(4),
    .HOLD_CYC  (2),
    .CNT_W     (4)
  ) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2.master)
  );

  logic       s_cs, s_wrb, s_rdb, s_rv, s_ready, s_oe;
  logic [1:0] s_addr;
  logic [7:0] s_rd, s_dout;
  assign s_cs    = sel ? bus2.cs        : bus1.cs;
  assign s_wrb   = sel ? bus2.wrb       : bus1.wrb;
  assign s_rdb   = sel ? bus2.rdb       : bus1.rdb;
  assign s_rv    = sel ? bus2.rsp_valid : bus1.rsp_valid;
  assign s_ready = sel ? bus2.req_ready : bus1.req_ready;
  assign s_oe    = sel ? bus2.data_oe   : bus1.data_oe;
  assign s_addr  = sel ? {bus2.a1, bus2.a0} : {bus1.a1, bus1.a0};
  assign s_rd    = sel ? bus2.rsp_rdata : bus1.rsp_rdata;
  assign s_dout  = sel ? bus2.data_out  : bus1.data_out;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       sel;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] din_a;     // data_in before the last strobe cycle
    logic [7:0] din_b;     // data_in during the last strobe cycle
    int         st_first;
    int         st_n;
    int         cs_n;
    int         rsp;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[6];

  // One transaction: accept at edge 0, trace cycles 1..rsp+1 sampled at the negedge.
  task automatic run_vec(input vec_t v);
    int c, cs_n, cs_first, st_n, st_first, bad, busy_ready, rsp_c, rsp_n, st_last;
    logic [7:0] rdata, dout;
    logic       oe, ready_after;
    logic [1:0] addr;
    sel = v.sel;
    st_last = v.st_first + v.st_n - 1;
    {cs_n, cs_first, st_n, st_first, bad, busy_ready, rsp_c, rsp_n} = '0;
    rdata = 8'hxx; dout = 8'hxx; oe = 1'bx; addr = 2'bxx; ready_after = 1'b0;
    @(negedge clk);
    check({v.name, "_ready_idle"}, 32'(s_ready), 32'd1);
    req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; din = v.din_a;
    if (v.sel) req_valid2 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0; req_valid2 = 1'b0;
    req_write = ~v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata;
    c = 0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (!s_cs) begin cs_n++; if (cs_first == 0) cs_first = c; end
      if (!(v.wr ? s_wrb : s_rdb)) begin st_n++; if (st_first == 0) st_first = c; end
      if (!(v.wr ? s_rdb : s_wrb)) bad++;
      if (s_ready && rsp_c == 0) busy_ready++;
      if (c == v.st_first) begin dout = s_dout; oe = s_oe; addr = s_addr; end
      if (s_rv) begin
        rsp_n++;
        if (rsp_c == 0) begin rsp_c = c; rdata = s_rd; end
      end
      if (c == st_last) din = v.din_b;
      else if (c == st_last + 1) din = ~v.din_b;
      if (rsp_c != 0 && c == rsp_c + 1) begin ready_after = s_ready; break; end
    end
    check({v.name, "_cs_first"}, 32'(cs_first), 32'd1);
    check({v.name, "_cs_n"}, 32'(cs_n), 32'(v.cs_n));
    check({v.name, "_st_first"}, 32'(st_first), 32'(v.st_first));
    check({v.name, "_st_n"}, 32'(st_n), 32'(v.st_n));
    check({v.name, "_other_strobe"}, 32'(bad), 32'd0);
    check({v.name, "_busy_ready"}, 32'(busy_ready), 32'd0);
    check({v.name, "_rsp_cycle"}, 32'(rsp_c), 32'(v.rsp));
    check({v.name, "_rsp_n"}, 32'(rsp_n), 32'd1);
    check({v.name, "_rdata"}, 32'(rdata), 32'(v.rdata));
    check({v.name, "_ready_after"}, 32'(ready_after), 32'd1);
    check({v.name, "_data_out"}, 32'(dout), 32'(v.wdata));
    check({v.name, "_data_oe"}, 32'(oe), 32'(v.wr));
    check({v.name, "_addr"}, 32'(addr), 32'(v.addr));
  endtask

  initial begin
    int wrb_first, wrb_n, rdb_first, rdb_n, overlap, r1, r2, acc2, bad_rv, cs_lo;
    logic [7:0] rd1, rd2, dout_c2;

    vecs[0] = '{"cwr_wr",   1'b0, 1'b1, 2'd3, 8'h9B, 8'h00, 8'h00, 2, 2, 4, 5, 8'h00};
    vecs[1] = '{"rd_a",     1'b0, 1'b0, 2'd0, 8'h5A, 8'hA5, 8'hA5, 2, 2, 4, 5, 8'hA5};
    vecs[2] = '{"rd_cap",   1'b0, 1'b0, 2'd2, 8'h00, 8'h11, 8'h22, 2, 2, 4, 5, 8'h22};
    vecs[3] = '{"wr_b",     1'b0, 1'b1, 2'd1, 8'h3C, 8'hFF, 8'hFF, 2, 2, 4, 5, 8'h00};
    vecs[4] = '{"param_wr", 1'b1, 1'b1, 2'd2, 8'hC3, 8'h00, 8'h00, 4, 4, 9, 10, 8'h00};
    vecs[5] = '{"param_rd", 1'b1, 1'b0, 2'd1, 8'h00, 8'h66, 8'h77, 4, 4, 9, 10, 8'h77};

    reset = 1'b1;
    req_valid1 = 1'b0; req_valid2 = 1'b0;
    req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'h00; din = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(s_cs), 32'd1);
    check("rst_wrb", 32'(s_wrb), 32'd1);
    check("rst_rdb", 32'(s_rdb), 32'd1);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_data_out", 32'(s_dout), 32'd0);
    check("rst_data_oe", 32'(s_oe), 32'd0);
    check("rst_rsp_valid", 32'(s_rv), 32'd0);
    check("rst_rsp_rdata", 32'(s_rd), 32'd0);
    check("rst_ready_low", 32'(s_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 32'(s_ready), 32'd1);

    // Reset held for two cycles in the middle of a write strobe.
    req_write = 1'b1; req_addr = 2'd3; req_wdata = 8'h9B; req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_strobe_low", 32'(s_wrb), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wrb", 32'(s_wrb), 32'd1);
    check("midrst_cs", 32'(s_cs), 32'd1);
    check("midrst_oe", 32'(s_oe), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bad_rv = 0; cs_lo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_rv) bad_rv++;
      if (!s_cs) cs_lo++;
    end
    check("midrst_no_rsp", 32'(bad_rv), 32'd0);
    check("midrst_cs_idle", 32'(cs_lo), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd1);

    // Back-to-back: valid held high across a write then a read.
    sel = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'hBC; din = 8'h35; req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_addr = 2'd1; req_wdata = 8'h00;
    {wrb_first, wrb_n, rdb_first, rdb_n, overlap, r1, r2, acc2} = '0;
    rd1 = 8'hxx; rd2 = 8'hxx; dout_c2 = 8'hxx;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (!s_wrb) begin wrb_n++; if (wrb_first == 0) wrb_first = c; end
      if (!s_rdb) begin rdb_n++; if (rdb_first == 0) rdb_first = c; end
      if (!s_wrb && !s_rdb) overlap++;
      if (c == 2) dout_c2 = s_dout;
      if (s_rv) begin
        if (r1 == 0) begin r1 = c; rd1 = s_rd; end
        else if (r2 == 0) begin r2 = c; rd2 = s_rd; end
      end
      if (s_ready && acc2 == 0) begin
        acc2 = c;
        @(posedge clk);
        #1 req_valid1 = 1'b0;
      end
    end
    req_valid1 = 1'b0;
    check("b2b_accept2", 32'(acc2), 32'd6);
    check("b2b_wrb_first", 32'(wrb_first), 32'd2);
    check("b2b_wrb_n", 32'(wrb_n), 32'd2);
    check("b2b_rdb_first", 32'(rdb_first), 32'd8);
    check("b2b_rdb_n", 32'(rdb_n), 32'd2);
    check("b2b_overlap", 32'(overlap), 32'd0);
    check("b2b_data_out", 32'(dout_c2), 32'hBC);
    check("b2b_rsp1", 32'(r1), 32'd5);
    check("b2b_rd1", 32'(rd1), 32'h00);
    check("b2b_rsp2", 32'(r2), 32'd11);
    check("b2b_rd2", 32'(rd2), 32'h35);

    foreach (vecs[i]) run_vec(vecs[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
